// File: rtl/dff_pipe_pkg.sv
// -----------------------------------------------------------------------------
// dff_pipe_pkg
// Shared definitions for the dff_pipe elastic register pipeline.
//   MAX_WIDTH / MAX_BYTES : widest word the byte-merge helper can handle
//   calc_nbytes()         : number of byte lanes in a WIDTH-bit word
//   be_merge()            : byte-enable mux between a new word and a shadow word
// -----------------------------------------------------------------------------
package dff_pipe_pkg;

   // be_merge works on a fixed wide vector so that a single package function
   // serves every WIDTH; callers zero-extend their operands and truncate the
   // result. WIDTH above MAX_WIDTH is not supported.
   localparam int MAX_WIDTH = 1024;
   localparam int MAX_BYTES = MAX_WIDTH / 8;

   // Number of byte lanes in a word of the given width.
   function automatic int calc_nbytes(input int width);
      return width / 8;
   endfunction

   // For every byte lane k: be[k] ? data byte k : shadow byte k.
   function automatic logic [MAX_WIDTH-1:0] be_merge(
      input logic [MAX_WIDTH-1:0] data,
      input logic [MAX_WIDTH-1:0] shadow,
      input logic [MAX_BYTES-1:0] be
   );
      logic [MAX_WIDTH-1:0] result;
      result = shadow;
      for (int k = 0; k < MAX_BYTES; k++) begin
         if (be[k]) begin
            result[8*k +: 8] = data[8*k +: 8];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// -----------------------------------------------------------------------------
// dff_pipe_if
// Handshake bundle for dff_pipe.
//   in_valid / in_ready / in_data / in_be : upstream word with byte enables
//   flush                                 : discard every in-flight word
//   out_valid / out_ready / out_data      : downstream word
//   occupancy                             : number of valid stages
// Modports: master = the side that feeds and drains the pipeline,
//           slave  = the pipeline itself.
// -----------------------------------------------------------------------------
interface dff_pipe_if
   import dff_pipe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
);

   localparam int OCC_W = $clog2(DEPTH + 1);

   logic                          in_valid;
   logic                          in_ready;
   logic [WIDTH-1:0]              in_data;
   logic [calc_nbytes(WIDTH)-1:0] in_be;
   logic                          flush;
   logic                          out_valid;
   logic                          out_ready;
   logic [WIDTH-1:0]              out_data;
   logic [OCC_W-1:0]              occupancy;

   modport master (
      output in_valid, in_data, in_be, flush, out_ready,
      input  in_ready, out_valid, out_data, occupancy
   );

   modport slave (
      input  in_valid, in_data, in_be, flush, out_ready,
      output in_ready, out_valid, out_data, occupancy
   );

endinterface

// File: rtl/dff_pipe_stage.sv
// -----------------------------------------------------------------------------
// dff_pipe_stage
// One valid+data register of the pipeline.
//   clk      : rising-edge clock
//   areset_n : asynchronous active-low reset (valid=0, data=RESET_VAL)
//   load     : take din this edge and become valid
//   advance  : the held word moves on this edge
//   flush    : drop the held word (data register is left untouched)
//   din      : word to load
//   valid    : stage holds a word
//   data     : stage word
// -----------------------------------------------------------------------------
module dff_pipe_stage #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             areset_n,
   input  logic             load,
   input  logic             advance,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // Flush wins over everything and only touches the valid bit. A load in
   // the same edge as an advance means the stage is refilled by its
   // predecessor, so it stays valid with the new word; an advance without
   // a refill leaves the stage empty but keeps the old data visible.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         valid <= 1'b0;
         data  <= RESET_VAL;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= din;
      end else if (advance) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/dff_pipe.sv
// -----------------------------------------------------------------------------
// dff_pipe
// Parametrised elastic register pipeline: WIDTH-bit words travel through
// DEPTH register stages under a valid/ready handshake with bubble collapse,
// byte-enable merge against the last accepted word, synchronous flush and
// an occupancy count.
//   clk      : rising-edge clock
//   areset_n : asynchronous active-low reset
//   bus      : dff_pipe_if.slave (in_valid/in_ready/in_data/in_be, flush,
//              out_valid/out_ready/out_data, occupancy)
// -----------------------------------------------------------------------------
module dff_pipe
   import dff_pipe_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic      clk,
   input  logic      areset_n,
   dff_pipe_if.slave bus
);

   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] advance;
   logic [WIDTH-1:0] stage_data [DEPTH];
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] merged;
   logic [OCC_W-1:0] occ;
   logic             in_ready;
   logic             in_xfer;
   logic             out_xfer;

   // Walk the stages from the output side back to the input. A stage can
   // hand its word on when the position ahead is empty or is itself moving
   // on this edge; the last stage hands on to the downstream via out_ready.
   // Because an empty stage always accepts, bubbles collapse independently
   // of out_ready.
   always_comb begin
      logic room;
      advance = '0;
      room    = bus.out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         advance[i] = valid[i] && room;
         room       = !valid[i] || advance[i];
      end
   end

   // Acceptance depends only on the stage bits, flush and out_ready, never
   // on in_valid. It is also held low while reset is asserted.
   assign in_ready = areset_n && !bus.flush && (!valid[0] || advance[0]);
   assign in_xfer  = bus.in_valid && in_ready;
   assign out_xfer = advance[DEPTH-1];

   // Byte-lane merge of the incoming word against the last accepted word.
   assign merged = WIDTH'(be_merge(MAX_WIDTH'(bus.in_data),
                                   MAX_WIDTH'(shadow),
                                   MAX_BYTES'(bus.in_be)));

   // Stage 0 loads merged input words; every later stage loads whatever its
   // predecessor hands on.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] din;
      logic             load;

      if (i == 0) begin : g_first
         assign din  = merged;
         assign load = in_xfer;
      end else begin : g_rest
         assign din  = stage_data[i-1];
         assign load = advance[i-1];
      end

      dff_pipe_stage #(
         .WIDTH    (WIDTH),
         .RESET_VAL(RESET_VAL)
      ) u_stage (
         .clk     (clk),
         .areset_n(areset_n),
         .load    (load),
         .advance (advance[i]),
         .flush   (bus.flush),
         .din     (din),
         .valid   (valid[i]),
         .data    (stage_data[i])
      );
   end

   // The shadow remembers the last accepted (already merged) word so the
   // next partial write can fill its disabled lanes from it. Flush leaves
   // it alone on purpose: a post-flush be=0 write re-sends it.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         shadow <= RESET_VAL;
      end else if (in_xfer) begin
         shadow <= merged;
      end
   end

   // Occupancy tracks accepted minus emitted words. in_ready never lets it
   // exceed DEPTH, and out_xfer only fires when a word is present, so it
   // cannot underflow.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         occ <= '0;
      end else if (bus.flush) begin
         occ <= '0;
      end else begin
         occ <= occ + OCC_W'(in_xfer) - OCC_W'(out_xfer);
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid[DEPTH-1];
   assign bus.out_data  = stage_data[DEPTH-1];
   assign bus.occupancy = occ;

endmodule

// File: tb/tb_dff_pipe.sv
// -----------------------------------------------------------------------------
// tb_dff_pipe
// Self-checking bench for dff_pipe. Two instances: dut_a (WIDTH=16, DEPTH=3,
// RESET_VAL=16'hA5A5) carries the streaming, backpressure, merge, flush and
// random tests; dut_b (WIDTH=8, DEPTH=1) is compared with a plain 8-bit DFF.
// -----------------------------------------------------------------------------
module tb_dff_pipe;

   localparam int          AW  = 16;
   localparam int          AD  = 3;
   localparam logic [15:0] ARV = 16'hA5A5;
   localparam logic [7:0]  BRV = 8'h5A;

   logic clk = 1'b0;
   logic areset_n = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dff_pipe_if #(.WIDTH(AW), .DEPTH(AD)) bus_a ();
   dff_pipe_if #(.WIDTH(8),  .DEPTH(1))  bus_b ();

   dff_pipe #(.WIDTH(AW), .DEPTH(AD), .RESET_VAL(ARV)) dut_a (
      .clk     (clk),
      .areset_n(areset_n),
      .bus     (bus_a)
   );

   dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(BRV)) dut_b (
      .clk     (clk),
      .areset_n(areset_n),
      .bus     (bus_b)
   );

   // Reference model for dut_a: an ordered list of in-flight words, each
   // with its age in edges since acceptance. The oldest word is visible at
   // the output once it has aged DEPTH-1 edges; the pipe is full when it
   // holds DEPTH words.
   typedef struct {
      logic [15:0] data;
      int          age;
   } word_t;

   word_t       mq[$];
   logic [15:0] m_shadow;
   logic [15:0] m_last;

   typedef struct {
      logic        iv;
      logic [15:0] d;
      logic [1:0]  be;
      logic        fl;
      logic        ordy;
      logic        ov;
      logic [15:0] od;
      int          occ;
      logic        ir;
   } vec_t;

   vec_t tbl[$];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
      end
   endtask

   function automatic logic [15:0] mergeBytes(input logic [15:0] d,
                                              input logic [15:0] s,
                                              input logic [1:0] be);
      logic [15:0] r;
      r[7:0]  = be[0] ? d[7:0]  : s[7:0];
      r[15:8] = be[1] ? d[15:8] : s[15:8];
      return r;
   endfunction

   task automatic modelReset();
      mq.delete();
      m_shadow = ARV;
      m_last   = ARV;
   endtask

   task automatic modelExpect(output logic ev, output logic [15:0] ed,
                              output int occ, output logic ir);
      ev  = (mq.size() > 0) && (mq[0].age >= AD - 1);
      ed  = ev ? mq[0].data : m_last;
      occ = mq.size();
      ir  = !bus_a.flush && ((mq.size() < AD) || (bus_a.out_ready && ev));
   endtask

   task automatic modelCheck(input string tag);
      logic ev, ir;
      logic [15:0] ed;
      int occ;
      modelExpect(ev, ed, occ, ir);
      checkOutput({tag, " out_valid"}, 32'(bus_a.out_valid), 32'(ev));
      checkOutput({tag, " out_data"},  32'(bus_a.out_data),  32'(ed));
      checkOutput({tag, " occupancy"}, 32'(bus_a.occupancy), 32'(occ));
      checkOutput({tag, " in_ready"},  32'(bus_a.in_ready),  32'(ir));
   endtask

   task automatic modelAdvance();
      logic ev, ir, outx, inx;
      logic [15:0] ed, mw;
      int occ;
      modelExpect(ev, ed, occ, ir);
      if (ev) m_last = ed;
      outx = ev && bus_a.out_ready;
      inx  = bus_a.in_valid && ir;
      if (bus_a.flush) begin
         mq.delete();
      end else begin
         if (outx) void'(mq.pop_front());
         for (int i = 0; i < mq.size(); i++) mq[i].age = mq[i].age + 1;
         if (inx) begin
            mw = mergeBytes(bus_a.in_data, m_shadow, bus_a.in_be);
            mq.push_back(word_t'{data: mw, age: 0});
            m_shadow = mw;
         end
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic [15:0] d,
                                input logic [1:0] be, input logic fl,
                                input logic ordy);
      @(negedge clk);
      bus_a.in_valid  = iv;
      bus_a.in_data   = d;
      bus_a.in_be     = be;
      bus_a.flush     = fl;
      bus_a.out_ready = ordy;
      #1;
   endtask

   // Asserts reset in the low phase, checks both instances before any clock
   // edge, then releases on the following falling edge with inputs idle.
   task automatic resetPulse();
      @(negedge clk);
      #2;
      bus_a.in_valid = 1'b0;
      bus_a.flush    = 1'b0;
      bus_b.in_valid = 1'b0;
      bus_b.flush    = 1'b0;
      areset_n       = 1'b0;
      #1;
      checkOutput("reset a out_valid", 32'(bus_a.out_valid), 32'(0));
      checkOutput("reset a out_data",  32'(bus_a.out_data),  32'(ARV));
      checkOutput("reset a occupancy", 32'(bus_a.occupancy), 32'(0));
      checkOutput("reset a in_ready",  32'(bus_a.in_ready),  32'(0));
      checkOutput("reset b out_valid", 32'(bus_b.out_valid), 32'(0));
      checkOutput("reset b out_data",  32'(bus_b.out_data),  32'(BRV));
      checkOutput("reset b in_ready",  32'(bus_b.in_ready),  32'(0));
      modelReset();
      @(negedge clk);
      areset_n = 1'b1;
   endtask

   task automatic addRow(input logic iv, input logic [15:0] d, input logic [1:0] be,
                         input logic fl, input logic ordy, input logic ov,
                         input logic [15:0] od, input int occ, input logic ir);
      tbl.push_back(vec_t'{iv: iv, d: d, be: be, fl: fl, ordy: ordy,
                           ov: ov, od: od, occ: occ, ir: ir});
   endtask

   initial begin
      bus_a.in_valid  = 1'b0;
      bus_a.in_data   = '0;
      bus_a.in_be     = '1;
      bus_a.flush     = 1'b0;
      bus_a.out_ready = 1'b1;
      bus_b.in_valid  = 1'b0;
      bus_b.in_data   = '0;
      bus_b.in_be     = 1'b1;
      bus_b.flush     = 1'b0;
      bus_b.out_ready = 1'b1;
      modelReset();

      resetPulse();

      // Streaming 1..10 with out_ready held: word k appears 3 rows after
      // the row that accepted it and the pipe settles full.
      for (int i = 0; i < 14; i++) begin
         applyStimulus(i < 10, 16'(i + 1), 2'b11, 1'b0, 1'b1);
         modelCheck("stream");
         if (i >= 3 && i <= 12) begin
            checkOutput("stream order", 32'(bus_a.out_data), 32'(i - 2));
            checkOutput("stream valid", 32'(bus_a.out_valid), 32'(1));
         end
         if (i >= 3 && i <= 10) checkOutput("stream occ", 32'(bus_a.occupancy), 32'(3));
         modelAdvance();
      end

      // Partially fill against backpressure, then reset mid-stream.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 16'hC0DE, 2'b11, 1'b0, 1'b0);
         modelCheck("prefill");
         modelAdvance();
      end
      resetPulse();

      // Hand-derived sequence: backpressure, byte merge, flush, be=0 resend.
      addRow(1, 16'h1111, 2'b11, 0, 0,  0, 16'hA5A5, 0, 1);
      addRow(1, 16'h2222, 2'b11, 0, 0,  0, 16'hA5A5, 1, 1);
      addRow(1, 16'h3333, 2'b11, 0, 0,  0, 16'hA5A5, 2, 1);
      addRow(1, 16'h4444, 2'b11, 0, 0,  1, 16'h1111, 3, 0);
      addRow(1, 16'h4444, 2'b11, 0, 0,  1, 16'h1111, 3, 0);
      addRow(1, 16'h4444, 2'b11, 0, 1,  1, 16'h1111, 3, 1);
      addRow(0, 16'h0000, 2'b11, 0, 1,  1, 16'h2222, 3, 1);
      addRow(0, 16'h0000, 2'b11, 0, 1,  1, 16'h3333, 2, 1);
      addRow(0, 16'h0000, 2'b11, 0, 1,  1, 16'h4444, 1, 1);
      addRow(1, 16'hBEEF, 2'b11, 0, 1,  0, 16'h4444, 0, 1);
      addRow(1, 16'h1234, 2'b01, 0, 1,  0, 16'h4444, 1, 1);
      addRow(1, 16'h5678, 2'b10, 0, 1,  0, 16'h4444, 2, 1);
      addRow(0, 16'h0000, 2'b11, 0, 1,  1, 16'hBEEF, 3, 1);
      addRow(0, 16'h0000, 2'b11, 0, 1,  1, 16'hBE34, 2, 1);
      addRow(0, 16'h0000, 2'b11, 0, 0,  1, 16'h5634, 1, 1);
      addRow(1, 16'h0101, 2'b11, 0, 0,  1, 16'h5634, 1, 1);
      addRow(1, 16'h0202, 2'b11, 0, 0,  1, 16'h5634, 2, 1);
      addRow(1, 16'h7777, 2'b11, 1, 0,  1, 16'h5634, 3, 0);
      addRow(1, 16'h0303, 2'b11, 0, 1,  0, 16'h5634, 0, 1);
      addRow(0, 16'h0000, 2'b11, 0, 1,  0, 16'h5634, 1, 1);
      addRow(0, 16'h0000, 2'b11, 0, 1,  0, 16'h5634, 1, 1);
      addRow(0, 16'h0000, 2'b11, 0, 1,  1, 16'h0303, 1, 1);
      addRow(1, 16'hFFFF, 2'b00, 0, 1,  0, 16'h0303, 0, 1);
      addRow(0, 16'h0000, 2'b11, 0, 1,  0, 16'h0303, 1, 1);
      addRow(0, 16'h0000, 2'b11, 0, 1,  0, 16'h0303, 1, 1);
      addRow(0, 16'h0000, 2'b11, 0, 1,  1, 16'h0303, 1, 1);
      addRow(0, 16'h0000, 2'b11, 0, 1,  0, 16'h0303, 0, 1);

      foreach (tbl[r]) begin
         applyStimulus(tbl[r].iv, tbl[r].d, tbl[r].be, tbl[r].fl, tbl[r].ordy);
         checkOutput($sformatf("vec%0d out_valid", r), 32'(bus_a.out_valid), 32'(tbl[r].ov));
         checkOutput($sformatf("vec%0d out_data", r),  32'(bus_a.out_data),  32'(tbl[r].od));
         checkOutput($sformatf("vec%0d occupancy", r), 32'(bus_a.occupancy), 32'(tbl[r].occ));
         checkOutput($sformatf("vec%0d in_ready", r),  32'(bus_a.in_ready),  32'(tbl[r].ir));
         modelAdvance();
      end

      // DEPTH=1 behaves as the original DFF: q is d from one edge earlier.
      begin
         logic [7:0] prev_d;
         prev_d = '0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus_b.in_valid  = 1'b1;
            bus_b.in_be     = 1'b1;
            bus_b.out_ready = 1'b1;
            bus_b.flush     = 1'b0;
            bus_b.in_data   = 8'($urandom);
            #1;
            if (i == 0) begin
               checkOutput("dff first valid", 32'(bus_b.out_valid), 32'(0));
               checkOutput("dff first data",  32'(bus_b.out_data),  32'(BRV));
            end else begin
               checkOutput("dff q", 32'(bus_b.out_data), 32'(prev_d));
               checkOutput("dff valid", 32'(bus_b.out_valid), 32'(1));
               checkOutput("dff occupancy", 32'(bus_b.occupancy), 32'(1));
            end
            checkOutput("dff in_ready", 32'(bus_b.in_ready), 32'(1));
            prev_d = bus_b.in_data;
         end
         @(negedge clk);
         bus_b.in_valid = 1'b0;
      end

      // Random traffic with occasional flush and asynchronous reset.
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 149) == 0) begin
            resetPulse();
         end else begin
            applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom),
                          $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7);
            modelCheck("rand");
            modelAdvance();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
